// File: rtl/branch_predictor_pkg.sv
// Shared constants for the F-stage BTB/BHT branch predictor.
// Optional gshare indexing is enabled with macro BP_GSHARE_EN.
package branch_predictor_pkg;

  localparam int BP_PC_W  = 13;
  localparam int BP_IDX_W = 6;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_BR   = 2'b01;
  localparam logic [1:0] KIND_JAL  = 2'b10;
  localparam logic [1:0] KIND_JALR = 2'b11;

  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and E-stage training bundle for the branch predictor.
// master = pipeline side, slave = predictor.
interface branch_predictor_if #(
  parameter int PC_W = 13
);

  logic [PC_W-1:0] f_pc;
  logic [PC_W-1:0] pred_pc;
  logic            pred_taken;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic [1:0]      upd_kind;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;

  modport master (
    output f_pc, upd_valid, upd_pc,
    output upd_kind, upd_taken, upd_target,
    input  pred_pc, pred_taken
  );

  modport slave (
    input  f_pc, upd_valid, upd_pc,
    input  upd_kind, upd_taken, upd_target,
    output pred_pc, pred_taken
  );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state function (00 floor, 11 ceiling).
// Used by the BHT update path of branch_predictor.
module bp_sat_counter (
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cnt;
    unique case (1'b1)
      inc && cnt != 2'b11:  nxt = cnt + 2'b01;
      !inc && cnt != 2'b00: nxt = cnt - 2'b01;
      default:              nxt = cnt;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT predictor, zero-latency lookup, registered training.
// Define BP_GSHARE_EN to XOR a global history register into the BHT index.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_W  = BP_PC_W,
  parameter int IDX_W = BP_IDX_W
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bus
);

  localparam int TAG_W = PC_W - IDX_W;
  localparam int N     = 1 << IDX_W;

  logic [N-1:0]     valid;
  logic [N-1:0]     is_jal;
  logic [TAG_W-1:0] tag    [N];
  logic [PC_W-1:0]  target [N];
  logic [1:0]       bht    [N];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] f_bidx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  logic [IDX_W-1:0] u_idx;
  logic [IDX_W-1:0] u_bidx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             br_upd;
  logic             jal_upd;
  logic [1:0]       cnt_nxt;

  assign f_idx = bus.f_pc[IDX_W-1:0];
  assign f_tag = bus.f_pc[PC_W-1:IDX_W];
  assign u_idx = bus.upd_pc[IDX_W-1:0];
  assign u_tag = bus.upd_pc[PC_W-1:IDX_W];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // History advances on every resolved conditional branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr <= '0;
    else if (br_upd) ghr <= {ghr[IDX_W-2:0], bus.upd_taken};
  end

  assign f_bidx = f_idx ^ ghr;
  assign u_bidx = u_idx ^ ghr;
`else
  assign f_bidx = f_idx;
  assign u_bidx = u_idx;
`endif

  assign f_hit = valid[f_idx] && (tag[f_idx] == f_tag);

  assign bus.pred_taken = f_hit && (is_jal[f_idx] || bht[f_bidx][1]);
  assign bus.pred_pc    = bus.pred_taken ? target[f_idx]
                                         : bus.f_pc + PC_W'(1);

  assign u_hit   = valid[u_idx] && (tag[u_idx] == u_tag);
  assign br_upd  = bus.upd_valid && (bus.upd_kind == KIND_BR);
  assign jal_upd = bus.upd_valid && (bus.upd_kind == KIND_JAL);

  bp_sat_counter u_cnt (
    .cnt (bht[u_bidx]),
    .inc (bus.upd_taken),
    .nxt (cnt_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      is_jal <= '0;
      for (int i = 0; i < N; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        bht[i]    <= BHT_WNT;
      end
    end else begin
      if (jal_upd) begin
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= u_tag;
        target[u_idx] <= bus.upd_target;
        is_jal[u_idx] <= 1'b1;
      end
      if (br_upd && u_hit) begin
        bht[u_bidx] <= cnt_nxt;
        if (bus.upd_taken) begin
          target[u_idx] <= bus.upd_target;
          is_jal[u_idx] <= 1'b0;
        end
      end
      // Taken miss evicts whatever occupied the slot.
      if (br_upd && !u_hit && bus.upd_taken) begin
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= u_tag;
        target[u_idx] <= bus.upd_target;
        is_jal[u_idx] <= 1'b0;
        bht[u_bidx]   <= BHT_WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random traffic.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int PC_W  = 13;
  localparam int IDX_W = 6;
  localparam int N     = 64;
  localparam int PCM   = 1 << PC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(PC_W)) bus ();

  branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic            t;
    logic [PC_W-1:0] pc;
    int              fpc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: a table of known branch sites and a counter per slot.
  bit mv[N];
  int mtag[N];
  int mtgt[N];
  bit mj[N];
  int mc[N];
  int hist;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mj[i] = 0; mc[i] = 1;
    end
    hist = 0;
  endfunction

  function automatic int bsel(input int pc);
`ifdef BP_GSHARE_EN
    return (pc % N) ^ hist;
`else
    return pc % N;
`endif
  endfunction

  function automatic void m_pred(input int pc, output bit t, output int npc);
    int i = pc % N;
    t = mv[i] && mtag[i] == pc / N && (mj[i] || mc[bsel(pc)] >= 2);
    npc = t ? mtgt[i] : (pc + 1) % PCM;
  endfunction

  function automatic void m_upd(input int pc, input int kind,
                                input bit tk, input int tgt);
    int i = pc % N;
    int b = bsel(pc);
    bit hit = mv[i] && mtag[i] == pc / N;
    if (kind == 2) begin
      mv[i] = 1; mtag[i] = pc / N; mtgt[i] = tgt; mj[i] = 1;
    end else if (kind == 1) begin
      if (hit) begin
        if (tk) begin
          mc[b] = (mc[b] < 3) ? mc[b] + 1 : 3;
          mtgt[i] = tgt; mj[i] = 0;
        end else begin
          mc[b] = (mc[b] > 0) ? mc[b] - 1 : 0;
        end
      end else if (tk) begin
        mv[i] = 1; mtag[i] = pc / N; mtgt[i] = tgt; mj[i] = 0; mc[b] = 2;
      end
      hist = ((hist << 1) | int'(tk)) % N;
    end
  endfunction

  task automatic step(input bit rst, input int fpc, input bit uv,
                      input int upc, input int kind, input bit tk,
                      input int tgt);
    bit t;
    int npc;
    exp_t e;
    @(negedge clk);
    rst_n = !rst;
    bus.f_pc = PC_W'(fpc);
    bus.upd_valid = uv;
    bus.upd_pc = PC_W'(upc);
    bus.upd_kind = 2'(kind);
    bus.upd_taken = tk;
    bus.upd_target = PC_W'(tgt);
    if (rst) m_reset();
    m_pred(fpc, t, npc);
    e.t = t; e.pc = PC_W'(npc); e.fpc = fpc;
    q.push_back(e);
    if (!rst && uv) m_upd(upc, kind, tk, tgt);
  endtask

  task automatic look(input int fpc);
    step(0, fpc, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input int fpc, input int upc, input int kind,
                     input bit tk, input int tgt);
    step(0, fpc, 1, upc, kind, tk, tgt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.pred_taken !== e.t || bus.pred_pc !== e.pc) begin
          failures++;
          $display("FAIL pred f_pc=%h got taken=%b pc=%h want taken=%b pc=%h",
                   e.fpc, bus.pred_taken, bus.pred_pc, e.t, e.pc);
        end
      end
    end
  end

  function automatic int rpc();
    int tags[4] = '{0, 1, 2, 127};
    return tags[$urandom_range(0, 3)] * N + int'($urandom_range(0, 7));
  endfunction

  initial begin : driver
    int fpc;
    bus.f_pc = '0; bus.upd_valid = 0; bus.upd_pc = '0;
    bus.upd_kind = '0; bus.upd_taken = 0; bus.upd_target = '0;
    m_reset();
    step(1, 'h0040, 0, 0, 0, 0, 0);
    step(1, 'h0040, 0, 0, 0, 0, 0);
    look('h0040);
    look('h1234);
    // JAL: same-cycle lookup still sees the old state
    upd('h0040, 'h0040, 2, 1, 'h0100);
    look('h0040);
    // conditional branch training and saturation
    upd('h0010, 'h0010, 1, 1, 'h0008);
    upd('h0010, 'h0010, 1, 1, 'h0008);
    upd('h0010, 'h0010, 1, 1, 'h0008);
    upd('h0010, 'h0010, 1, 0, 'h0008);
    look('h0010);
    upd('h0010, 'h0010, 1, 0, 'h0008);
    upd('h0010, 'h0010, 1, 0, 'h0008);
    look('h0010);
    look('h0050);
    look('h1FFF);
    upd('h0020, 'h0020, 3, 1, 'h0777);
    look('h0020);
    upd('h0020, 'h0021, 1, 0, 'h0333);
    look('h0021);
    // alternating pattern, then reset in the middle of an update
    for (int k = 0; k < 8; k++) upd('h0010, 'h0010, 1, k[0] == 0, 'h0008);
    for (int k = 0; k < 4; k++) upd('h0010, 'h0010, 1, k[0] == 0, 'h0008);
    step(1, 'h0040, 1, 'h0040, 2, 1, 'h0100);
    look('h0040);
    look('h0010);
    for (int k = 0; k < 600; k++) begin
      fpc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, PCM - 1)) : rpc();
      if ($urandom_range(0, 99) == 0)
        step(1, fpc, 1, rpc(), 2, 1, 0);
      else
        step(0, fpc, $urandom_range(0, 3) != 0, rpc(),
             int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             int'($urandom_range(0, PCM - 1)));
    end
    look('h1FFF);
    @(negedge clk);
    @(negedge clk);
    #4;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
